// File: rtl/shift_sequencer.sv
// Shift sequencer: accepts one word, shifts or rotates it one bit per clock
// for the requested amount, then presents the result until it is taken.
module shift_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [1:0]                 in_ctrl,
   input  logic [$clog2(WIDTH)-1:0]   in_amt,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       busy
);

   localparam int AW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   state_t            nxt;
   logic [WIDTH-1:0]  work;
   logic [AW-1:0]     cnt;
   logic [1:0]        ctrl_q;
   logic              accept;

   // One-bit move of the working word: 00 lsl, 01 lsr, 10 rol, 11 ror
   function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] w,
                                              input logic [1:0]       op);
      logic [WIDTH-1:0] r;
      case (op)
         2'b00:   r = {w[WIDTH-2:0], 1'b0};
         2'b01:   r = {1'b0, w[WIDTH-1:1]};
         2'b10:   r = {w[WIDTH-2:0], w[WIDTH-1]};
         default: r = {w[0], w[WIDTH-1:1]};
      endcase
      return r;
   endfunction

   assign accept = in_valid & in_ready;

   // State register; reset aborts any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Next-state: SHIFT ends on the edge that sees a zero count
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (accept) nxt = SHIFT;
         SHIFT:   if (cnt == '0) nxt = DONE;
         DONE:    if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Datapath: capture on accept, shift while counting, publish on the way into DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work     <= '0;
         cnt      <= '0;
         ctrl_q   <= 2'b00;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  work   <= in_data;
                  ctrl_q <= in_ctrl;
                  cnt    <= in_amt;
               end
            end
            SHIFT: begin
               if (cnt == '0) begin
                  out_data <= work;
               end else begin
                  work <= step1(work, ctrl_q);
                  cnt  <= cnt - AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected words are queued at accept
// and compared when the result is presented.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  in_ctrl;
   logic [4:0]  in_amt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] sb[$];

   shift_sequencer #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .in_amt    (in_amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result computed in one step from the request
   function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] c, input int a);
      logic [63:0] dd;
      case (c)
         2'b00: return d << a;
         2'b01: return d >> a;
         2'b10: begin dd = {d, d} << a; return dd[63:32]; end
         default: begin dd = {d, d} >> a; return dd[31:0]; end
      endcase
   endfunction

   task automatic do_op(input logic [31:0] d, input logic [1:0] c, input int a,
                        input int hold, input bit perturb);
      int lat;
      logic [31:0] held, exp;
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = d; in_ctrl = c; in_amt = 5'(a);
      sb.push_back(model(d, c, a));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         check("busy_shift", 32'(busy), 32'd1);
         check("in_ready_shift", 32'(in_ready), 32'd0);
         if (perturb) begin
            in_data = $urandom;
            in_ctrl = 2'($urandom_range(0, 3));
            in_amt  = 5'($urandom_range(0, 31));
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("latency", 32'(lat), 32'(a + 1));
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_data", out_data, held);
         @(posedge clk);
         @(negedge clk);
      end
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         exp = 32'hx;
      end else begin
         exp = sb.pop_front();
      end
      check("result", out_data, exp);
      check("done_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_data_hold", out_data, exp);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = 2'b00; in_amt = '0; out_ready = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      do_op(32'h00000009, 2'b00, 1, 0, 1'b0);
      do_op(32'h9EAB389A, 2'b01, 4, 0, 1'b0);
      do_op(32'h80000001, 2'b10, 1, 0, 1'b0);
      do_op(32'h00000001, 2'b11, 31, 0, 1'b0);
      do_op(32'h00000005, 2'b00, 0, 3, 1'b0);
      do_op(32'hA5A5F00F, 2'b10, 7, 0, 1'b1);
      do_op(32'hC3000F18, 2'b01, 13, 1, 1'b1);
      for (int k = 0; k < 8; k++)
         do_op($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 31),
               $urandom_range(0, 2), 1'b0);

      // Abort mid-shift with an asynchronous reset
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h12345678; in_ctrl = 2'b00; in_amt = 5'd20;
      sb.push_back(model(32'h12345678, 2'b00, 20));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_data", out_data, 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      if (sb.size() != 0) void'(sb.pop_front());
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_valid", 32'(seen), 32'd0);
      do_op(32'h00000009, 2'b00, 1, 0, 1'b0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, data word width, a power of two and at least 2.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  sequencer can accept a request.
REQ-007 in_data  input  WIDTH  word to shift.
REQ-008 in_ctrl  input  2  operation: 00 left logical, 01 right logical, 10 rotate left, 11 rotate right.
REQ-009 in_amt  input  $clog2(WIDTH)  shift amount, 0..WIDTH-1.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  WIDTH  shifted result, registered.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; there is no accept while in SHIFT or DONE.
REQ-016 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; that edge SHALL:
- load in_data into the working register;
- latch in_ctrl;
- load a down-counter with in_amt;
- move to SHIFT.
REQ-017 In SHIFT with counter=0, the next edge SHALL move to DONE with the working register unchanged.
REQ-018 In SHIFT with counter>0, each edge SHALL perform a one-bit shift per the latched ctrl and decrement the counter.
- Logical shifts SHALL fill with 0.
- Rotates SHALL move the exiting bit into the vacated end.
REQ-019 Latency SHALL be in_amt+1 rising edges from the accept edge to the first cycle of out_valid=1, including in_amt=0 (latency 1).
REQ-020 In DONE:
- out_valid SHALL be 1;
- out_data SHALL equal the working register and remain stable until handshake.
REQ-021 A DONE cycle with out_ready=1 SHALL complete the handshake, and the next edge SHALL return to IDLE; out_ready held low SHALL hold DONE indefinitely.
REQ-022 out_valid SHALL be 0 in IDLE and SHIFT; out_data SHALL hold its last value outside DONE.
REQ-023 in_data, in_ctrl and in_amt SHALL be ignored except on the accept edge; input changes during SHIFT SHALL NOT affect the result.
REQ-024 Back-to-back operation: the earliest next accept SHALL be the edge after the DONE->IDLE edge, so throughput is at most one request per in_amt+3 cycles.
REQ-025 Result SHALL equal the single-step combinational equivalent: in_data << amt, >> amt, or rotated by amt, truncated to WIDTH.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for a clock, force:
- state to IDLE;
- counter to 0, working register to 0, latched ctrl to 00;
- out_valid=0, out_data=0, busy=0, in_ready=1.
REQ-027 Reset asserted during SHIFT or DONE SHALL abort the operation and discard its result; no out_valid pulse SHALL follow.
REQ-028 After rst deasserts, the first rising edge with in_valid=1 SHALL be a valid accept.

Verification
REQ-029 Left logical, in_data=0x00000009, amt=1 -> out_data=0x00000012, out_valid at accept+2 edges.
REQ-030 Right logical, in_data=0x9EAB389A, amt=4 -> out_data=0x09EAB389, out_valid at accept+5 edges, busy high throughout.
REQ-031 Rotate left, 0x80000001, amt=1 -> 0x00000003; rotate right, 0x00000001, amt=31 -> 0x00000002 at accept+32 edges.
REQ-032 Amt=0, in_data=0x00000005 with out_ready low for 3 cycles -> out_data=0x00000005 stable, out_valid=1 and in_ready=0 during all 3 cycles; IDLE one edge after out_ready rises.
REQ-033 Reset pulse mid-SHIFT (amt=20, after 5 shifts) -> out_valid=0, in_ready=1 and out_data=0 asynchronously; a following request for 0x00000009, left, amt=1 returns 0x00000012.
REQ-034 Input perturbation: change in_data and in_ctrl every cycle during SHIFT -> result matches the values latched at accept.
